regrd_arb: RTL and testbench

Round-robin arbiter that shares the single 8:1 × 16-bit register-file read port between up to four requesters (execution unit, effective-address calculator, string unit, etc.). Each cycle it picks one pending request, steers that requester's 3-bit register select through the port, and returns the registered read data with a requester ID one cycle later. It sits between the register file and its consumers and replaces per-consumer read muxes.

---
 rtl/regrd_arb.sv | 135 +++++++++++++
 tb/tb_regrd_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regrd_arb.sv
// regrd_arb: round-robin arbiter sharing one 8:1 x 16-bit register-file read port among NREQ requesters.
// Define REGRD_ARB_BYPASS_EN to forward a same-cycle register write into the returned read data.
module regrd_arb #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] sel,
  input  logic [127:0]      regs,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [15:0]       wr_data,
  output logic [NREQ-1:0]   gnt,
  output logic [15:0]       rdata,
  output logic              rvalid,
  output logic [1:0]        rid
);

  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rid_q, rid_d;

  logic [3:0]      elig_w_s;
  logic [11:0]     sel_w_s;
  logic [2:0]      idx_s;
  logic            found_s;
  logic [1:0]      win_s;
  logic [2:0]      win_sel_s;
  logic [15:0]     rd_s;
  logic [2:0]      ptr_nxt_s;

  // Winner search: last cycle's grantee is masked so a held req is not served twice in a row.
  always_comb begin
    elig_w_s = 4'b0000;
    elig_w_s[NREQ-1:0] = req & ~gnt_q;
    found_s = 1'b0;
    win_s = 2'd0;
    idx_s = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_q} + 3'(k);
      if (idx_s >= 3'(NREQ)) begin
        idx_s = idx_s - 3'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && elig_w_s[idx_s[1:0]]) begin
        found_s = 1'b1;
        win_s = idx_s[1:0];
      end else begin
        found_s = found_s;
        win_s = win_s;
      end
    end
  end

  // Read-port steering: winner's register select picks one 16-bit register.
  always_comb begin
    sel_w_s = 12'h000;
    sel_w_s[3*NREQ-1:0] = sel;
    case (win_s)
      2'd0:    win_sel_s = sel_w_s[2:0];
      2'd1:    win_sel_s = sel_w_s[5:3];
      2'd2:    win_sel_s = sel_w_s[8:6];
      2'd3:    win_sel_s = sel_w_s[11:9];
      default: win_sel_s = 3'd0;
    endcase
`ifdef REGRD_ARB_BYPASS_EN
    if (wr_en && (wr_addr == win_sel_s)) begin
      rd_s = wr_data;
    end else begin
      rd_s = regs[{win_sel_s, 4'd0} +: 16];
    end
`else
    rd_s = regs[{win_sel_s, 4'd0} +: 16];
`endif
  end

`ifndef REGRD_ARB_BYPASS_EN
  logic unused_wr_s;
  assign unused_wr_s = ^{wr_en, wr_addr, wr_data};
`endif

  // Next values: grant on a free edge, otherwise clear the pulse and keep data, id and pointer.
  always_comb begin
    gnt_d     = {NREQ{1'b0}};
    rvalid_d  = 1'b0;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    ptr_d     = ptr_q;
    ptr_nxt_s = {1'b0, win_s} + 3'd1;
    if (!hold && found_s) begin
      for (int i = 0; i < NREQ; i++) begin
        gnt_d[i] = (win_s == 2'(i));
      end
      rvalid_d = 1'b1;
      rid_d    = win_s;
      rdata_d  = rd_s;
      if (ptr_nxt_s >= 3'(NREQ)) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = ptr_nxt_s[1:0];
      end
    end else begin
      gnt_d    = {NREQ{1'b0}};
      rvalid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= 2'd0;
      gnt_q    <= {NREQ{1'b0}};
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
      rid_q    <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
    end
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;

endmodule

// File: tb/tb_regrd_arb.sv
// Scoreboard bench for regrd_arb (NREQ=3): expectations queued with stimulus, compared after each edge.
module tb_regrd_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hold = 1'b0;
  logic [2:0]   req = 3'b000;
  logic [8:0]   sel = 9'd0;
  logic [127:0] regs;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = 3'd0;
  logic [15:0]  wr_data = 16'h0000;
  logic [2:0]   gnt;
  logic [15:0]  rdata;
  logic         rvalid;
  logic [1:0]   rid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  gnt;
    logic        rvalid;
    logic [15:0] rdata;
    logic [1:0]  rid;
  } exp_t;

  exp_t exp_q[$];

`ifdef REGRD_ARB_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hABCD;
`else
  localparam logic [15:0] BYP_EXP = 16'h1234;
`endif

  regrd_arb #(.NREQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req(req), .sel(sel), .regs(regs),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    req = 3'b000; hold = 1'b0; wr_en = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    checks++; if (rid !== 2'd0) begin failures++; $display("FAIL reset_rid got=%0d exp=0", rid); end
    rst_n = 1'b1;
    sel = {3'd7, 3'd5, 3'd2};
    req = 3'b111;
    exp_q.push_back('{3'b001, 1'b1, 16'h1234, 2'd0});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL reset_pregrant gnt got=%b exp=%b", gnt, e.gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_async_gnt got=%b exp=000", gnt); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_async_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_async_rdata got=%h exp=0000", rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back('{3'b001, 1'b1, 16'h1234, 2'd0});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL reset_first gnt got=%b exp=%b", gnt, e.gnt); end
    checks++; if (rid !== e.rid) begin failures++; $display("FAIL reset_first rid got=%0d exp=%0d", rid, e.rid); end
    checks++; if (rdata !== e.rdata) begin failures++; $display("FAIL reset_first rdata got=%h exp=%h", rdata, e.rdata); end
    req = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [2:0] req_tbl [6] = '{3'b111, 3'b110, 3'b100, 3'b011, 3'b010, 3'b000};
    exp_t e_tbl [6] = '{'{3'b001, 1'b1, 16'h1234, 2'd0}, '{3'b010, 1'b1, 16'hBEEF, 2'd1},
                        '{3'b100, 1'b1, 16'h7777, 2'd2}, '{3'b001, 1'b1, 16'h1234, 2'd0},
                        '{3'b010, 1'b1, 16'hBEEF, 2'd1}, '{3'b000, 1'b0, 16'h0000, 2'd0}};
    exp_t e;
    do_reset();
    sel = {3'd7, 3'd5, 3'd2};
    for (int i = 0; i < 6; i++) begin
      req = req_tbl[i];
      exp_q.push_back(e_tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL rr gnt cyc=%0d got=%b exp=%b", i, gnt, e.gnt); end
      checks++; if (rvalid !== e.rvalid) begin failures++; $display("FAIL rr rvalid cyc=%0d got=%b exp=%b", i, rvalid, e.rvalid); end
      if (e.rvalid) begin
        checks++; if (rdata !== e.rdata) begin failures++; $display("FAIL rr rdata cyc=%0d got=%h exp=%h", i, rdata, e.rdata); end
        checks++; if (rid !== e.rid) begin failures++; $display("FAIL rr rid cyc=%0d got=%0d exp=%0d", i, rid, e.rid); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    sel = {3'd0, 3'd5, 3'd0};
    req = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back('{3'b010, 1'b1, 16'hBEEF, 2'd1});
      else exp_q.push_back('{3'b000, 1'b0, 16'hBEEF, 2'd1});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL b2b gnt cyc=%0d got=%b exp=%b", i, gnt, e.gnt); end
      checks++; if (rvalid !== e.rvalid) begin failures++; $display("FAIL b2b rvalid cyc=%0d got=%b exp=%b", i, rvalid, e.rvalid); end
      if (e.rvalid) begin
        checks++; if (rdata !== e.rdata) begin failures++; $display("FAIL b2b rdata cyc=%0d got=%h exp=%h", i, rdata, e.rdata); end
        checks++; if (rid !== e.rid) begin failures++; $display("FAIL b2b rid cyc=%0d got=%0d exp=%0d", i, rid, e.rid); end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_hold();
    logic [2:0] req_tbl [6] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b100, 3'b000};
    logic       hold_tbl [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e_tbl [6] = '{'{3'b000, 1'b0, 16'h0000, 2'd0}, '{3'b000, 1'b0, 16'h0000, 2'd0},
                        '{3'b000, 1'b0, 16'h0000, 2'd0}, '{3'b010, 1'b1, 16'hBEEF, 2'd1},
                        '{3'b100, 1'b1, 16'h7777, 2'd2}, '{3'b000, 1'b0, 16'h0000, 2'd0}};
    exp_t e;
    do_reset();
    sel = {3'd7, 3'd5, 3'd2};
    for (int i = 0; i < 6; i++) begin
      req = req_tbl[i];
      hold = hold_tbl[i];
      exp_q.push_back(e_tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL hold gnt cyc=%0d got=%b exp=%b", i, gnt, e.gnt); end
      checks++; if (rvalid !== e.rvalid) begin failures++; $display("FAIL hold rvalid cyc=%0d got=%b exp=%b", i, rvalid, e.rvalid); end
      if (e.rvalid) begin
        checks++; if (rdata !== e.rdata) begin failures++; $display("FAIL hold rdata cyc=%0d got=%h exp=%h", i, rdata, e.rdata); end
        checks++; if (rid !== e.rid) begin failures++; $display("FAIL hold rid cyc=%0d got=%0d exp=%0d", i, rid, e.rid); end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_bypass();
    logic [2:0] req_tbl [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
    logic [2:0] wa_tbl [4] = '{3'd2, 3'd2, 3'd3, 3'd3};
    exp_t e_tbl [4] = '{'{3'b001, 1'b1, BYP_EXP, 2'd0}, '{3'b000, 1'b0, 16'h0000, 2'd0},
                        '{3'b001, 1'b1, 16'h1234, 2'd0}, '{3'b000, 1'b0, 16'h0000, 2'd0}};
    exp_t e;
    do_reset();
    sel = {3'd7, 3'd5, 3'd2};
    wr_en = 1'b1;
    wr_data = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      req = req_tbl[i];
      wr_addr = wa_tbl[i];
      exp_q.push_back(e_tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL byp gnt cyc=%0d got=%b exp=%b", i, gnt, e.gnt); end
      if (e.rvalid) begin
        checks++; if (rdata !== e.rdata) begin failures++; $display("FAIL byp rdata cyc=%0d got=%h exp=%h", i, rdata, e.rdata); end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_withdrawal();
    logic [2:0] req_tbl [5] = '{3'b101, 3'b000, 3'b011, 3'b001, 3'b000};
    exp_t e_tbl [5] = '{'{3'b001, 1'b1, 16'h1234, 2'd0}, '{3'b000, 1'b0, 16'h0000, 2'd0},
                        '{3'b010, 1'b1, 16'hBEEF, 2'd1}, '{3'b001, 1'b1, 16'h1234, 2'd0},
                        '{3'b000, 1'b0, 16'h0000, 2'd0}};
    exp_t e;
    do_reset();
    sel = {3'd7, 3'd5, 3'd2};
    for (int i = 0; i < 5; i++) begin
      req = req_tbl[i];
      exp_q.push_back(e_tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL wd gnt cyc=%0d got=%b exp=%b", i, gnt, e.gnt); end
      checks++; if (rvalid !== e.rvalid) begin failures++; $display("FAIL wd rvalid cyc=%0d got=%b exp=%b", i, rvalid, e.rvalid); end
      if (e.rvalid) begin
        checks++; if (rid !== e.rid) begin failures++; $display("FAIL wd rid cyc=%0d got=%0d exp=%0d", i, rid, e.rid); end
      end
    end
  endtask

  initial begin
    regs = {16'h7777, 16'h6666, 16'hBEEF, 16'h4444, 16'h3333, 16'h1234, 16'h1111, 16'h0000};
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_hold();
    test_bypass();
    test_withdrawal();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
